// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with programmable modulus and step,
// synchronous clamped load, count enable, and runtime wrap/saturate selection.
module updown_counter_param #(
  parameter int WIDTH     = 4,
  parameter int MAX_VAL   = 2**WIDTH-1,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic [WIDTH-1:0] step,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_zero,
  output logic             wrap_pulse,
  output logic             sat_hit
);

  localparam int               MOD_I   = MAX_VAL + 1;
  localparam longint           STEP_HI = (longint'(1) << WIDTH) - 1;
  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]   MOD_C   = (WIDTH+1)'(MOD_I);
  localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VAL);

  generate
    if (WIDTH < 2 || MAX_VAL < 1 || longint'(MAX_VAL) > STEP_HI) begin : g_bad_max
      $error("updown_counter_param: WIDTH or MAX_VAL out of range");
    end
    if (RESET_VAL < 0 || RESET_VAL > MAX_VAL) begin : g_bad_reset
      $error("updown_counter_param: RESET_VAL must not exceed MAX_VAL");
    end
  endgenerate

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_sat;

  logic [WIDTH-1:0] w_count_next;
  logic             w_wrap_next;
  logic             w_sat_next;

  // step mod (MAX_VAL+1) by restoring reduction: one conditional subtract of
  // each shifted modulus that can still fit under the largest possible step.
  logic [WIDTH-1:0] w_rem [0:WIDTH];
  assign w_rem[0] = step;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_mod
      localparam longint SUB_I = longint'(MOD_I) << (WIDTH - 1 - gi);
      if (SUB_I <= STEP_HI) begin : g_sub
        localparam logic [WIDTH-1:0] SUB_C = WIDTH'(SUB_I);
        assign w_rem[gi+1] = (w_rem[gi] >= SUB_C) ? (w_rem[gi] - SUB_C) : w_rem[gi];
      end else begin : g_pass
        assign w_rem[gi+1] = w_rem[gi];
      end
    end
  endgenerate

  logic [WIDTH-1:0] w_step_mod;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_up_raw;
  logic [WIDTH:0]   w_dn_raw;
  logic [WIDTH-1:0] w_up_wrap;
  logic [WIDTH-1:0] w_dn_wrap;

  assign w_step_mod = w_rem[WIDTH];
  assign w_sum      = {1'b0, r_count} + {1'b0, step};
  assign w_up_raw   = {1'b0, r_count} + {1'b0, w_step_mod};
  assign w_dn_raw   = {1'b0, r_count} + MOD_C - {1'b0, w_step_mod};
  assign w_up_wrap  = WIDTH'((w_up_raw >= MOD_C) ? (w_up_raw - MOD_C) : w_up_raw);
  assign w_dn_wrap  = WIDTH'((w_dn_raw >= MOD_C) ? (w_dn_raw - MOD_C) : w_dn_raw);

  always_comb begin
    w_count_next = r_count;
    w_wrap_next  = 1'b0;
    w_sat_next   = 1'b0;
    if (load) begin
      if (load_val > MAX_C) begin
        w_count_next = MAX_C;
        w_sat_next   = 1'b1;
      end else begin
        w_count_next = load_val;
      end
    end else if (en && (step != '0)) begin
      if (up_down) begin
        if (w_sum <= {1'b0, MAX_C}) begin
          w_count_next = w_sum[WIDTH-1:0];
        end else if (sat_mode) begin
          w_count_next = MAX_C;
          w_sat_next   = 1'b1;
        end else begin
          w_count_next = w_up_wrap;
          w_wrap_next  = 1'b1;
        end
      end else begin
        if (step <= r_count) begin
          w_count_next = r_count - step;
        end else if (sat_mode) begin
          w_count_next = '0;
          w_sat_next   = 1'b1;
        end else begin
          w_count_next = w_dn_wrap;
          w_wrap_next  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= RESET_C;
      r_wrap  <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_wrap  <= w_wrap_next;
      r_sat   <= w_sat_next;
    end
  end

  assign count      = r_count;
  assign at_max     = (r_count == MAX_C);
  assign at_zero    = (r_count == '0);
  assign wrap_pulse = r_wrap;
  assign sat_hit    = r_sat;

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: directed corners plus random stimulus on a
// MAX_VAL=9 and a full-width MAX_VAL=15 instance, checked against an integer model.
module tb_updown_counter_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0, up_down = 1'b0, sat_mode = 1'b0, load = 1'b0;
  logic [3:0] step = 4'd0, load_val = 4'd0;

  logic [3:0] a_count, b_count;
  logic       a_at_max, a_at_zero, a_wrap, a_sat;
  logic       b_at_max, b_at_zero, b_wrap, b_sat;

  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(0)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .step(step),
    .sat_mode(sat_mode), .load(load), .load_val(load_val), .count(a_count),
    .at_max(a_at_max), .at_zero(a_at_zero), .wrap_pulse(a_wrap), .sat_hit(a_sat)
  );

  updown_counter_param #(.WIDTH(4), .MAX_VAL(15), .RESET_VAL(0)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .step(step),
    .sat_mode(sat_mode), .load(load), .load_val(load_val), .count(b_count),
    .at_max(b_at_max), .at_zero(b_at_zero), .wrap_pulse(b_wrap), .sat_hit(b_sat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] c;
    logic       w;
    logic       s;
  } mres_t;

  mres_t ma, mb;
  int    n_vec = 0;
  int    n_chk = 0;
  int    n_bad = 0;
  bit    chk_en = 1'b0;

  // Next state straight from the counting rules, in plain integers.
  function automatic mres_t model_next(input mres_t cur, input int mx);
    int    c, s;
    mres_t r;
    r.w = 1'b0;
    r.s = 1'b0;
    c = int'(cur.c);
    if (load) begin
      if (int'(load_val) > mx) begin c = mx; r.s = 1'b1; end
      else c = int'(load_val);
    end else if (en && step != 4'd0) begin
      if (up_down) begin
        s = c + int'(step);
        if (s <= mx) c = s;
        else if (sat_mode) begin c = mx; r.s = 1'b1; end
        else begin c = (s - (mx + 1)) % (mx + 1); r.w = 1'b1; end
      end else begin
        if (int'(step) <= c) c = c - int'(step);
        else if (sat_mode) begin c = 0; r.s = 1'b1; end
        else begin c = (c + (mx + 1) - int'(step) % (mx + 1)) % (mx + 1); r.w = 1'b1; end
      end
    end
    r.c = 4'(c);
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ma <= '0;
      mb <= '0;
    end else begin
      ma <= model_next(ma, 9);
      mb <= model_next(mb, 15);
    end
  end

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_count",   8'(a_count),   8'(ma.c));
      check("a_at_max",  8'(a_at_max),  8'(ma.c == 4'd9));
      check("a_at_zero", 8'(a_at_zero), 8'(ma.c == 4'd0));
      check("a_wrap",    8'(a_wrap),    8'(ma.w));
      check("a_sat",     8'(a_sat),     8'(ma.s));
      check("b_count",   8'(b_count),   8'(mb.c));
      check("b_at_max",  8'(b_at_max),  8'(mb.c == 4'd15));
      check("b_at_zero", 8'(b_at_zero), 8'(mb.c == 4'd0));
      check("b_wrap",    8'(b_wrap),    8'(mb.w));
      check("b_sat",     8'(b_sat),     8'(mb.s));
    end
  end

  // Drives one cycle's inputs just after an edge; optional short reset pulse between edges.
  task automatic apply(input logic ld, input logic [3:0] lv, input logic e, input logic ud,
                       input logic [3:0] st, input logic sm, input bit rp);
    load = ld; load_val = lv; en = e; up_down = ud; step = st; sat_mode = sm;
    if (rp) begin
      #1 reset = 1'b1;
      #1 reset = 1'b0;
    end
    @(posedge clk);
    #2;
    n_vec++;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    chk_en = 1'b1;
    check("rst_count", 8'(a_count), 8'd0);
    check("rst_wrap",  8'(a_wrap),  8'd0);
    check("rst_sat",   8'(a_sat),   8'd0);

    // Reset mid-count
    apply(1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    check("load5", 8'(a_count), 8'd5);
    #1 reset = 1'b1;
    #1;
    check("async_rst_count", 8'(a_count), 8'd0);
    check("async_rst_zero",  8'(a_at_zero), 8'd1);
    reset = 1'b0;
    apply(1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
    check("post_rst_count", 8'(a_count), 8'd1);

    // Wrap up
    apply(1'b1, 4'd8, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    apply(1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
    check("wrap_up_count", 8'(a_count), 8'd1);
    check("wrap_up_pulse", 8'(a_wrap),  8'd1);
    apply(1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
    check("wrap_up_hold",  8'(a_count), 8'd1);
    check("wrap_up_clear", 8'(a_wrap),  8'd0);

    // Saturate down, twice
    apply(1'b1, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    apply(1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0);
    check("sat_dn_count", 8'(a_count),   8'd0);
    check("sat_dn_hit",   8'(a_sat),     8'd1);
    check("sat_dn_zero",  8'(a_at_zero), 8'd1);
    apply(1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0);
    check("sat_dn_again", 8'(a_sat),     8'd1);

    // Exact upper bound
    apply(1'b1, 4'd6, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    apply(1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
    check("exact_count", 8'(a_count),  8'd9);
    check("exact_max",   8'(a_at_max), 8'd1);
    check("exact_wrap",  8'(a_wrap),   8'd0);
    check("exact_sat",   8'(a_sat),    8'd0);

    // Load priority and clamp
    apply(1'b1, 4'd14, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
    check("clamp_count", 8'(a_count), 8'd9);
    check("clamp_sat",   8'(a_sat),   8'd1);
    check("b_load14",    8'(b_count), 8'd14);
    apply(1'b1, 4'd3, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
    check("load3_count", 8'(a_count), 8'd3);
    check("load3_sat",   8'(a_sat),   8'd0);

    // Wrap down with a step larger than the modulus
    apply(1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    apply(1'b0, 4'd0, 1'b1, 1'b0, 4'd15, 1'b0, 1'b0);
    check("wrap_dn_count", 8'(a_count), 8'd6);
    check("wrap_dn_pulse", 8'(a_wrap),  8'd1);

    // Full-width corner on the MAX_VAL=15 instance
    apply(1'b1, 4'd15, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    check("b_full_max", 8'(b_at_max), 8'd1);
    apply(1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
    check("b_full_count", 8'(b_count), 8'd0);
    check("b_full_wrap",  8'(b_wrap),  8'd1);

    for (int i = 0; i < 2000; i++) begin
      logic [3:0] st;
      st = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      apply($urandom_range(0, 7) == 0, 4'($urandom), $urandom_range(0, 5) != 0,
            1'($urandom), st, 1'($urandom), $urandom_range(0, 99) == 0);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
